// File: rtl/encrypt_round_pipe.sv
// encrypt_round_pipe: one AES forward round (SubBytes, ShiftRows,
// MixColumns, AddRoundKey) followed by a globally stalled register pipe.
module encrypt_round_pipe #(
  parameter int DATA_WIDTH  = 128,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_final,
  input  logic                  keyLen,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [DATA_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] prev_key,
  input  logic [DATA_WIDTH-1:0] key_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] state_out,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);

  if (DATA_WIDTH != 128) begin : g_bad_width
    $error("DATA_WIDTH must be 128");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("PIPE_STAGES must be 1..4");
  end

  localparam int CW = $clog2(PIPE_STAGES + 1);
  localparam int L  = PIPE_STAGES - 1;

  // Byte x lives at bits {~x,3'b000} +: 8 (entry 0x00 is the MSB byte).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_round(
    input logic [127:0] st,
    input logic         fin,
    input logic [127:0] key
  );
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      s[i] = sbox(st[127-8*i -: 8]);
    // Byte index is row + 4*col; row r rotates left by r.
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        t[rw+4*c] = s[rw+4*((c+rw)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (fin)
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        r[127-32*c -: 32] = {
          xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
          a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
          a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
          xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
        };
    end
    return r ^ key;
  endfunction

  logic                  vld_q [PIPE_STAGES];
  logic                  vld_d [PIPE_STAGES];
  logic [DATA_WIDTH-1:0] dat_q [PIPE_STAGES];
  logic [DATA_WIDTH-1:0] dat_d [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]  tag_q [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]  tag_d [PIPE_STAGES];
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  stall;
  logic                  acc;
  logic                  cons;

  assign out_valid = vld_q[L];
  assign state_out = dat_q[L];
  assign out_tag   = tag_q[L];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign acc       = in_valid && in_ready;
  assign cons      = out_valid && out_ready;
  assign busy      = (cnt_q != '0);

  always_comb begin
    for (int i = 0; i < PIPE_STAGES; i++) begin
      vld_d[i] = vld_q[i];
      dat_d[i] = dat_q[i];
      tag_d[i] = tag_q[i];
    end
    cnt_d = cnt_q;
    if (!stall) begin
      vld_d[0] = acc;
      dat_d[0] = aes_round(state_in, in_final,
                           keyLen ? prev_key : key_in);
      tag_d[0] = in_tag;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
    case ({acc, cons})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
        tag_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
        tag_q[i] <= tag_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_encrypt_round_pipe.sv
// tb_encrypt_round_pipe: directed FIPS-197 vectors, streaming, stall and
// reset scenarios plus random traffic against a byte-matrix AES model.
module tb_encrypt_round_pipe;

  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_final = 1'b0;
  logic         keyLen = 1'b0;
  logic [3:0]   in_tag = '0;
  logic [127:0] state_in = '0;
  logic [127:0] prev_key = '0;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] state_out;
  logic [3:0]   out_tag;
  logic         busy;

  encrypt_round_pipe #(
    .DATA_WIDTH (128),
    .PIPE_STAGES(P),
    .TAG_WIDTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_final (in_final),
    .keyLen   (keyLen),
    .in_tag   (in_tag),
    .state_in (state_in),
    .prev_key (prev_key),
    .key_in   (key_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .state_out(state_out),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tg, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from first principles: GF(2^8) inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
            ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] mcoef(input int r, input int k);
    int d;
    d = (k - r + 4) % 4;
    return (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] st,
                                             input bit fin,
                                             input logic [127:0] k);
    logic [7:0]   m  [4][4];
    logic [7:0]   sr [4][4];
    logic [7:0]   o  [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = sb[st[127-8*(r+4*c) -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r][c] = m[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (fin) o[r][c] = sr[r][c];
        else begin
          o[r][c] = 8'h00;
          for (int q = 0; q < 4; q++)
            o[r][c] = o[r][c] ^ gmul(mcoef(r, q), sr[q][c]);
        end
      end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(r+4*c) -: 8] = o[r][c];
    return res ^ k;
  endfunction

  typedef struct {
    bit           v;
    logic [127:0] d;
    logic [3:0]   t;
  } slot_t;

  // pipe[0] is the slot presented on the output.
  slot_t pipe[$];

  task automatic model_clear();
    slot_t s;
    s.v = 1'b0;
    s.d = '0;
    s.t = '0;
    pipe.delete();
    repeat (P) pipe.push_back(s);
  endtask

  function automatic int model_cnt();
    int n;
    n = 0;
    foreach (pipe[i]) if (pipe[i].v) n++;
    return n;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, pipe[0].v);
    chk("in_ready", in_ready, !pipe[0].v || out_ready);
    chk("busy", busy, model_cnt() != 0);
    chk("count", dut.cnt_q, model_cnt());
    if (pipe[0].v) begin
      chk("state_out", state_out, pipe[0].d);
      chk("out_tag", out_tag, pipe[0].t);
    end
  endtask

  // One clock: predict, advance model at the edge, check 1 unit later.
  task automatic cycle();
    bit    stall;
    slot_t s;
    stall = pipe[0].v && !out_ready;
    s.v = in_valid && !stall;
    s.d = ref_round(state_in, in_final, keyLen ? prev_key : key_in);
    s.t = in_tag;
    @(posedge clk);
    if (rst) model_clear();
    else if (!stall) begin
      void'(pipe.pop_front());
      pipe.push_back(s);
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic rand_inputs();
    state_in = r128();
    prev_key = r128();
    key_in   = r128();
    in_final = 1'($urandom_range(0, 1));
    keyLen   = 1'($urandom_range(0, 1));
    in_tag   = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int           first_o, last_o, nseen, k;
    logic [127:0] held_d;
    logic [3:0]   held_t;

    build_sbox();
    model_clear();

    // Reset state
    rst = 1'b1;
    cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state_out", state_out, 128'h0);
    chk("rst_out_tag", out_tag, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    cycle();
    rst = 1'b0;

    // FIPS-197 App. B round 1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_final  = 1'b0;
    keyLen    = 1'b0;
    in_tag    = 4'h5;
    state_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    key_in    = 128'ha0fafe1788542cb123a339392a6c7605;
    prev_key  = r128();
    cycle();
    in_valid = 1'b0;
    state_in = r128();
    key_in   = r128();
    repeat (P - 1) cycle();
    chk("fips_r1_valid", out_valid, 1'b1);
    chk("fips_r1", state_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
    chk("fips_r1_tag", out_tag, 4'h5);
    cycle();

    // FIPS-197 final round via prev_key
    in_valid = 1'b1;
    in_final = 1'b1;
    keyLen   = 1'b1;
    in_tag   = 4'ha;
    state_in = 128'heb40f21e592e38848ba113e71bc342d2;
    prev_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_in   = r128();
    cycle();
    in_valid = 1'b0;
    in_final = 1'b0;
    keyLen   = 1'b0;
    prev_key = r128();
    repeat (P - 1) cycle();
    chk("fips_final_valid", out_valid, 1'b1);
    chk("fips_final", state_out, 128'h3925841d02dc09fbdc118597196a0b32);
    cycle();

    // Back-to-back stream, tags 0..7
    first_o = -1;
    last_o  = -1;
    nseen   = 0;
    for (int i = 0; i < 8 + P + 3; i++) begin
      if (i < 8) begin
        rand_inputs();
        in_tag   = 4'(i);
        in_valid = 1'b1;
      end else
        in_valid = 1'b0;
      cycle();
      if (out_valid) begin
        chk("stream_tag", out_tag, 4'(nseen));
        nseen++;
        if (first_o < 0) first_o = i;
        last_o = i;
      end
      if (last_o >= 0 && i == last_o + 1)
        chk("stream_busy_fall", busy, 1'b0);
    end
    chk("stream_count", nseen, 8);
    chk("stream_contig", last_o - first_o + 1, 8);

    // Backpressure: fill, hold 5 cycles, release
    out_ready = 1'b0;
    k = 0;
    while (in_ready && k < 10) begin
      rand_inputs();
      in_tag   = 4'(k + 8);
      in_valid = 1'b1;
      cycle();
      k++;
    end
    chk("bp_fill_bound", k <= P, 1'b1);
    chk("bp_full_cnt", dut.cnt_q, P);
    held_d = pipe[0].d;
    held_t = pipe[0].t;
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      cycle();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_data", state_out, held_d);
      chk("bp_hold_tag", out_tag, held_t);
      chk("bp_hold_cnt", dut.cnt_q, P);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (P + 2) cycle();

    // Simultaneous accept and consume with the pipe full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    k = 0;
    while (in_ready && k < 10) begin
      rand_inputs();
      cycle();
      k++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle();
      chk("simul_cnt", dut.cnt_q, P);
    end
    in_valid = 1'b0;
    repeat (P + 1) cycle();

    // Reset mid-stream with 2 blocks in flight
    in_valid = 1'b1;
    rand_inputs();
    cycle();
    rand_inputs();
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_state_out", state_out, 128'h0);
    chk("mrst_in_ready", in_ready, 1'b1);
    model_clear();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < P + 3; i++) begin
      cycle();
      chk("mrst_no_stale", out_valid, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (P + 2) cycle();
    chk("drain_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
